// File: rtl/hex_display_driver_if.sv
// Load-side and display-side signals of the hex display driver.
// The master drives the value and strobe; the slave returns segments and ack.
interface hex_display_driver_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] data_in;
    logic                load;
    logic                blank_lz;
    logic [DIGITS-1:0]   blink_mask;
    logic [7*DIGITS-1:0] data_out;
    logic                ack;

    modport master (
        output data_in,
        output load,
        output blank_lz,
        output blink_mask,
        input  data_out,
        input  ack
    );

    modport slave (
        input  data_in,
        input  load,
        input  blank_lz,
        input  blink_mask,
        output data_out,
        output ack
    );
endinterface

// File: rtl/hex_display_driver.sv
// Registered seven-segment driver for DIGITS hex digits with
// leading-zero blanking, per-digit blinking and selectable polarity.
module hex_display_driver #(
    parameter int DIGITS     = 4,
    parameter int BLINK_DIV  = 25000000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input logic clk,
    input logic rst,
    hex_display_driver_if.slave bus
);
    localparam int CW = $clog2(BLINK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);
    localparam logic [7*DIGITS-1:0] OUT_BLANK =
        ACTIVE_LOW ? '1 : '0;

    logic [4*DIGITS-1:0] val_q;
    logic                lz_q;
    logic [DIGITS-1:0]   mask_q;
    logic [CW-1:0]       cnt_q;
    logic                phase_q;
    logic                pend_q;
    logic                ack_q;
    logic [7*DIGITS-1:0] out_q;
    logic [7*DIGITS-1:0] out_d;

    // Active-low gfedcba pattern of one hex nibble.
    function automatic logic [6:0] seg_lo(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Walk from the top digit; lead stays set while only zeros seen.
    always_comb begin
        logic       lead;
        logic       blank;
        logic [3:0] nib;
        logic [6:0] seg;
        lead  = 1'b1;
        blank = 1'b0;
        nib   = '0;
        seg   = '0;
        out_d = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib = val_q[4*i +: 4];
            if (nib != 4'd0 || i == 0)
                lead = 1'b0;
            blank = (lz_q && lead) ||
                    (!phase_q && mask_q[i]);
            seg = blank ? 7'b1111111 : seg_lo(nib);
            out_d[7*i +: 7] = ACTIVE_LOW ? seg : ~seg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q   <= '0;
            lz_q    <= 1'b0;
            mask_q  <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b1;
            pend_q  <= 1'b0;
            ack_q   <= 1'b0;
            out_q   <= OUT_BLANK;
        end else begin
            if (bus.load) begin
                val_q  <= bus.data_in;
                lz_q   <= bus.blank_lz;
                mask_q <= bus.blink_mask;
            end
            if (cnt_q == CNT_MAX) begin
                cnt_q   <= '0;
                phase_q <= ~phase_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            pend_q <= bus.load;
            ack_q  <= pend_q;
            out_q  <= out_d;
        end
    end

    assign bus.data_out = out_q;
    assign bus.ack      = ack_q;
endmodule

// File: tb/tb_hex_display_driver.sv
// Bench for hex_display_driver: per-cycle model comparison on two
// instances (active-low and active-high) plus literal spot checks.
module tb_hex_display_driver;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hex_display_driver_if #(.DIGITS(4)) a_if ();
    hex_display_driver_if #(.DIGITS(4)) b_if ();

    hex_display_driver #(
        .DIGITS(4), .BLINK_DIV(DIV), .ACTIVE_LOW(1'b1)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(a_if)
    );

    hex_display_driver #(
        .DIGITS(4), .BLINK_DIV(DIV), .ACTIVE_LOW(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(b_if)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name,
                         input logic [27:0] act,
                         input logic [27:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    logic [6:0] font [16];
    initial begin
        font = '{7'h40, 7'h79, 7'h24, 7'h30,
                 7'h19, 7'h12, 7'h02, 7'h78,
                 7'h00, 7'h10, 7'h08, 7'h03,
                 7'h46, 7'h21, 7'h06, 7'h0E};
    end

    function automatic logic [27:0] render(
        input logic [15:0] v, input logic lz,
        input logic [3:0] m, input logic vis,
        input logic al);
        logic [27:0] r;
        logic [6:0]  s;
        int top;
        top = 0;
        for (int i = 0; i < 4; i++)
            if (((v >> (4*i)) & 16'hF) != 0) top = i;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            s = font[(v >> (4*i)) & 16'hF];
            if (lz && i > top) s = 7'h7F;
            if (!vis && m[i])  s = 7'h7F;
            if (!al) s = ~s;
            r[7*i +: 7] = s;
        end
        return r;
    endfunction

    // Model state: what each instance has captured and cycles since reset.
    logic [15:0] m_val  [2];
    logic        m_lz   [2];
    logic [3:0]  m_mask [2];
    logic        m_pend [2];
    int          m_edges = 0;
    logic [27:0] exp_out [2];
    logic        exp_ack [2];
    logic        m_valid = 1'b0;

    always @(posedge clk) begin
        logic vis;
        logic        ld  [2];
        logic [15:0] din [2];
        logic        dlz [2];
        logic [3:0]  dmk [2];
        ld[0] = a_if.load;  din[0] = a_if.data_in;
        dlz[0] = a_if.blank_lz; dmk[0] = a_if.blink_mask;
        ld[1] = b_if.load;  din[1] = b_if.data_in;
        dlz[1] = b_if.blank_lz; dmk[1] = b_if.blink_mask;
        vis = ((m_edges / DIV) % 2) == 0;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                exp_out[k] = (k == 0) ? 28'hFFFFFFF : 28'h0;
                exp_ack[k] = 1'b0;
                m_val[k] = '0; m_lz[k] = 1'b0;
                m_mask[k] = '0; m_pend[k] = 1'b0;
            end else begin
                exp_out[k] = render(m_val[k], m_lz[k],
                    m_mask[k], vis, k == 0);
                exp_ack[k] = m_pend[k];
                m_pend[k] = ld[k];
                if (ld[k]) begin
                    m_val[k] = din[k]; m_lz[k] = dlz[k];
                    m_mask[k] = dmk[k];
                end
            end
        end
        m_edges = rst ? 0 : m_edges + 1;
        m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("a_out", a_if.data_out, exp_out[0]);
            check("a_ack", 28'(a_if.ack), 28'(exp_ack[0]));
            check("b_out", b_if.data_out, exp_out[1]);
            check("b_ack", 28'(b_if.ack), 28'(exp_ack[1]));
        end
    end

    task automatic load_a(input logic [15:0] v,
                          input logic lz, input logic [3:0] m);
        a_if.data_in = v; a_if.blank_lz = lz;
        a_if.blink_mask = m; a_if.load = 1'b1;
        @(posedge clk); #1;
        a_if.load = 1'b0;
    endtask

    task automatic load_b(input logic [15:0] v,
                          input logic lz, input logic [3:0] m);
        b_if.data_in = v; b_if.blank_lz = lz;
        b_if.blink_mask = m; b_if.load = 1'b1;
        @(posedge clk); #1;
        b_if.load = 1'b0;
    endtask

    localparam logic [6:0] Z = 7'b1000000;
    localparam logic [6:0] BL = 7'b1111111;

    initial begin
        int on_n;
        int off_n;
        a_if.data_in = '0; a_if.load = 1'b0;
        a_if.blank_lz = 1'b0; a_if.blink_mask = '0;
        b_if.data_in = '0; b_if.load = 1'b0;
        b_if.blank_lz = 1'b0; b_if.blink_mask = '0;

        // Reset
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_out", a_if.data_out, 28'hFFFFFFF);
        check("rst_ack", 28'(a_if.ack), 28'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rel_ack", 28'(a_if.ack), 28'h0);
        @(posedge clk); #1;

        // Plain decode, ack timing
        load_a(16'h12AD, 1'b0, 4'b0000);
        @(negedge clk);
        check("ack_k", 28'(a_if.ack), 28'h0);
        @(negedge clk);
        check("ack_k1", 28'(a_if.ack), 28'h1);
        check("12AD", a_if.data_out,
              {7'b1111001, 7'b0100100, 7'b0001000, 7'b0100001});
        @(negedge clk);
        check("ack_k2", 28'(a_if.ack), 28'h0);

        // Leading-zero suppression
        load_a(16'h0070, 1'b1, 4'b0000);
        repeat (2) @(negedge clk);
        check("lz_0070", a_if.data_out, {BL, BL, 7'b1111000, Z});
        load_a(16'h0000, 1'b1, 4'b0000);
        repeat (2) @(negedge clk);
        check("lz_0000", a_if.data_out, {BL, BL, BL, Z});

        // Back-to-back loads
        load_a(16'h0001, 1'b0, 4'b0000);
        load_a(16'hF000, 1'b0, 4'b0000);
        @(negedge clk);
        check("b2b_ack1", 28'(a_if.ack), 28'h1);
        @(negedge clk);
        check("b2b_ack2", 28'(a_if.ack), 28'h1);
        check("F000", a_if.data_out, {7'b0001110, Z, Z, Z});

        // Blink on digit 0
        load_a(16'h0005, 1'b0, 4'b0001);
        @(negedge clk);
        on_n = 0; off_n = 0;
        repeat (16) begin
            @(negedge clk);
            if (a_if.data_out[6:0] == 7'b0010010) on_n++;
            if (a_if.data_out[6:0] == BL) off_n++;
            check("blink_hi", a_if.data_out[27:7], {Z, Z, Z});
        end
        check("blink_on", 28'(on_n), 28'd8);
        check("blink_off", 28'(off_n), 28'd8);

        // Reset wins over load
        rst = 1'b1;
        a_if.data_in = 16'hFFFF; a_if.load = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; a_if.load = 1'b0;
        @(negedge clk);
        check("rl_out", a_if.data_out, 28'hFFFFFFF);
        check("rl_ack", 28'(a_if.ack), 28'h0);
        @(negedge clk);
        check("rl_nocap", a_if.data_out, {Z, Z, Z, Z});
        check("rl_ack2", 28'(a_if.ack), 28'h0);
        @(posedge clk); #1;

        // Active-high polarity
        load_b(16'h8888, 1'b0, 4'b0000);
        repeat (2) @(negedge clk);
        check("ah_8888", b_if.data_out, 28'hFFFFFFF);
        load_b(16'h0000, 1'b1, 4'b0000);
        repeat (2) @(negedge clk);
        check("ah_lz", b_if.data_out,
              {7'h00, 7'h00, 7'h00, 7'b0111111});

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hex_display_driver.md
Name: hex_display_driver

Overview:
- Parametrised, registered driver for DIGITS seven-segment hex digits on the DE1 HEX displays.
- Captures a packed hex value on a load strobe and decodes every nibble to a segment pattern.
- Adds leading-zero blanking, per-digit blinking and selectable segment polarity.
- Sits between the datapath and the board HEX pins; supersedes per-digit combinational decoders.

Parameters:
DIGITS, 4, number of hex digits driven (1..8)
BLINK_DIV, 25000000, blink half-period in clk cycles (>= 2); 0.5 s at 50 MHz
ACTIVE_LOW, 1, 1 = segment on when 0 (DE1 boards); 0 = segment on when 1

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
data_in  input  4*DIGITS  packed value; nibble i drives digit i (digit 0 = LSB, rightmost)
load  input  1  capture strobe for data_in, blank_lz and blink_mask
blank_lz  input  1  leading-zero suppression enable, captured with load
blink_mask  input  DIGITS  bit i = 1 makes digit i blink, captured with load
data_out  output  7*DIGITS  segments; bits [7i+6:7i] = digit i, order gfedcba
ack  output  1  one-cycle pulse: the most recent load is now visible on data_out

Behaviour:
- One clock. Reset is synchronous and active-high. rst has priority over load in the same cycle.
- Reset values:
  - value register 0, lz register 0, mask register 0;
  - blink counter 0, blink phase 1 (visible);
  - ack 0;
  - data_out all digits blank (all 1s if ACTIVE_LOW=1, all 0s otherwise).
- Capture:
  - load=1 at edge k registers data_in, blank_lz and blink_mask at edge k.
  - data_out reflects the new value after edge k+1; ack=1 for the cycle following edge k+1.
  - No backpressure: load is accepted every cycle. Back-to-back loads each produce an ack, each one cycle behind its load.
- Decode (active-low form, gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - blank=1111111
  - ACTIVE_LOW=0 inverts every pattern, including blank.
- Leading-zero suppression (lz register = 1):
  - Scan from digit DIGITS-1 downward; each zero digit is blanked until the first non-zero digit.
  - Digit 0 is never suppressed, so an all-zero value shows a single "0".
- Blink:
  - Free-running counter counts 0..BLINK_DIV-1 and wraps to 0; the blink phase toggles on each wrap.
  - The counter is independent of load and cleared only by rst.
  - Phase 0: every digit whose mask bit is 1 is blanked. Blinking overrides the decoded pattern; suppressed digits stay blank in both phases.
- data_out is fully registered: no combinational path from any input to data_out or ack.

Test Plan:
1. Reset with DIGITS=4, 5 cycles of rst=1 -> data_out=28'hFFFFFFF, ack=0 throughout and on the first cycle after release.
2. load=1 for one cycle with data_in=16'h12AD, blank_lz=0, mask=0 -> two edges later digit3=1111001, digit2=0100100, digit1=0001000, digit0=0100001; ack high exactly one cycle.
3. load with 16'h0070, blank_lz=1 -> digit3=digit2=1111111, digit1=1111000, digit0=1000000. Then load 16'h0000, blank_lz=1 -> digits 3..1 blank, digit0=1000000.
4. BLINK_DIV=4, load 16'h0005, blank_lz=0, mask=4'b0001 -> digit0 alternates 0010010 and 1111111 every 4 cycles; digits 3..1 hold 1000000 steadily.
5. Assert rst and load (data_in=16'hFFFF) in the same cycle during blinking -> next edge data_out all 1s and ack=0; the value is not captured.
6. ACTIVE_LOW=0 instance, load 16'h8888 -> data_out=28'hFFFFFFF. Then load 16'h0000 with blank_lz=1 -> digits 3..1 = 0000000, digit0=0111111.
